// File: rtl/sfu_pkg.sv
// Shared types and default widths for the SFU sequencing controller.
package sfu_pkg;

   localparam int SFU_SEL_W  = 4;
   localparam int SFU_PASS_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/sfu_rowpass_cnt.sv
// Nested row/pass counter with captured limits; flags the final element of a job.
module sfu_rowpass_cnt
   import sfu_pkg::*;
#(
   parameter int SEL_W  = SFU_SEL_W,
   parameter int PASS_W = SFU_PASS_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [SEL_W-1:0]  i_cfg_last_row,
   input  logic [PASS_W-1:0] i_cfg_last_pass,
   input  logic              i_clr,
   input  logic              i_en,
   output logic [SEL_W-1:0]  o_row,
   output logic [SEL_W-1:0]  o_last_row,
   output logic              o_final
);

   logic [SEL_W-1:0]  r_row;
   logic [SEL_W-1:0]  r_last_row;
   logic [PASS_W-1:0] r_pass;
   logic [PASS_W-1:0] r_last_pass;
   logic              w_row_last;
   logic              w_pass_last;

   assign w_row_last  = (r_row == r_last_row);
   assign w_pass_last = (r_pass == r_last_pass);
   assign o_row       = r_row;
   assign o_last_row  = r_last_row;
   assign o_final     = w_row_last && w_pass_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row       <= '0;
         r_pass      <= '0;
         r_last_row  <= '0;
         r_last_pass <= '0;
      end else begin
         if (i_load) begin
            r_last_row  <= i_cfg_last_row;
            r_last_pass <= i_cfg_last_pass;
         end
         if (i_load || i_clr) begin
            r_row  <= '0;
            r_pass <= '0;
         end else if (i_en) begin
            // The final element returns both counters to 0 so pass never exceeds its limit.
            if (w_row_last) begin
               r_row  <= '0;
               r_pass <= w_pass_last ? '0 : r_pass + PASS_W'(1);
            end else begin
               r_row <= r_row + SEL_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sfu_seq_ctrl.sv
// SFU job sequencer: clear, stream FIFO psums into accumulators, then sweep them out through ReLU.
module sfu_seq_ctrl
   import sfu_pkg::*;
#(
   parameter int SEL_W  = SFU_SEL_W,
   parameter int PASS_W = SFU_PASS_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SEL_W-1:0]  cfg_last_row,
   input  logic [PASS_W-1:0] cfg_last_pass,
   input  logic              ofifo_valid,
   output logic              ofifo_rd,
   input  logic              out_ready,
   output logic              sfu_clr,
   output logic              sfu_acc,
   output logic              sfu_relu,
   output logic [SEL_W-1:0]  sfu_sel,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   state_t           r_state;
   state_t           w_next;
   logic             w_load;
   logic             w_cnt_clr;
   logic [SEL_W-1:0] w_row;
   logic [SEL_W-1:0] w_last_row;
   logic             w_final;

   logic             w_nx_clr;
   logic             w_nx_acc;
   logic             w_nx_relu;
   logic [SEL_W-1:0] w_nx_sel;
   logic             w_nx_valid;
   logic             w_nx_done;

   assign ofifo_rd = (r_state == ST_ACCUM) && ofifo_valid;

   sfu_rowpass_cnt #(
      .SEL_W  (SEL_W),
      .PASS_W (PASS_W)
   ) u_cnt (
      .clk             (clk),
      .reset           (reset),
      .i_load          (w_load),
      .i_cfg_last_row  (cfg_last_row),
      .i_cfg_last_pass (cfg_last_pass),
      .i_clr           (w_cnt_clr),
      .i_en            (ofifo_rd),
      .o_row           (w_row),
      .o_last_row      (w_last_row),
      .o_final         (w_final)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_cnt_clr  = 1'b0;
      w_nx_clr   = 1'b0;
      w_nx_acc   = 1'b0;
      w_nx_relu  = 1'b0;
      w_nx_sel   = sfu_sel;
      w_nx_valid = 1'b0;
      w_nx_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load   = 1'b1;
               w_nx_clr = 1'b1;
               w_next   = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_cnt_clr = 1'b1;
            w_next    = ST_ACCUM;
         end
         ST_ACCUM: begin
            // The accumulate strobe lags the read by one cycle to meet the FIFO data.
            if (ofifo_valid) begin
               w_nx_acc = 1'b1;
               w_nx_sel = w_row;
               if (w_final) begin
                  w_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!out_valid) begin
               w_nx_relu  = 1'b1;
               w_nx_valid = 1'b1;
               w_nx_sel   = '0;
            end else if (out_ready) begin
               if (sfu_sel == w_last_row) begin
                  w_nx_done = 1'b1;
                  w_next    = ST_FIN;
               end else begin
                  w_nx_relu  = 1'b1;
                  w_nx_valid = 1'b1;
                  w_nx_sel   = sfu_sel + SEL_W'(1);
               end
            end else begin
               w_nx_relu  = 1'b1;
               w_nx_valid = 1'b1;
            end
         end
         ST_FIN: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sfu_clr   <= 1'b0;
         sfu_acc   <= 1'b0;
         sfu_relu  <= 1'b0;
         sfu_sel   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         sfu_clr   <= w_nx_clr;
         sfu_acc   <= w_nx_acc;
         sfu_relu  <= w_nx_relu;
         sfu_sel   <= w_nx_sel;
         out_valid <= w_nx_valid;
         busy      <= (w_next != ST_IDLE);
         done      <= w_nx_done;
      end
   end

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Self-checking bench for sfu_seq_ctrl: job-level reference model plus literal job expectations.
module tb_sfu_seq_ctrl;

   localparam int SEL_W  = 4;
   localparam int PASS_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [SEL_W-1:0]  cfg_last_row;
   logic [PASS_W-1:0] cfg_last_pass;
   logic              ofifo_valid;
   logic              ofifo_rd;
   logic              out_ready;
   logic              sfu_clr;
   logic              sfu_acc;
   logic              sfu_relu;
   logic [SEL_W-1:0]  sfu_sel;
   logic              out_valid;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   sfu_seq_ctrl #(
      .SEL_W  (SEL_W),
      .PASS_W (PASS_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg_last_row  (cfg_last_row),
      .cfg_last_pass (cfg_last_pass),
      .ofifo_valid   (ofifo_valid),
      .ofifo_rd      (ofifo_rd),
      .out_ready     (out_ready),
      .sfu_clr       (sfu_clr),
      .sfu_acc       (sfu_acc),
      .sfu_relu      (sfu_relu),
      .sfu_sel       (sfu_sel),
      .out_valid     (out_valid),
      .busy          (busy),
      .done          (done)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
      end
   endtask

   // Stimulus modes for the FIFO-valid and out-ready drivers.
   int vmode  = 0;
   int rmode  = 0;
   int bp_cnt = 0;

   always @(posedge clk) begin
      #1;
      case (vmode)
         0:       ofifo_valid = 1'b1;
         1:       ofifo_valid = ~ofifo_valid;
         2:       ofifo_valid = (($urandom % 4) != 0);
         default: ofifo_valid = 1'b0;
      endcase
      case (rmode)
         0: out_ready = 1'b1;
         1: out_ready = (($urandom % 3) != 0);
         default: begin
            if (out_valid === 1'b1 && sfu_sel == 4'd5 && bp_cnt < 3) begin
               out_ready = 1'b0;
               bp_cnt++;
            end else begin
               out_ready = 1'b1;
            end
         end
      endcase
   end

   // Job-level reference model: counts reads and outputs against the captured limits.
   bit m_on      = 1'b0;
   bit m_active  = 1'b0;
   bit m_prev_rd = 1'b0;
   int m_cyc, m_reads, m_outs, m_total, m_n, m_last_read_cyc, m_fin_cyc;

   int mon_reads = 0;
   int mon_outs  = 0;
   int mon_done  = 0;
   int mon_sel5  = 0;

   always @(negedge clk) begin
      bit e_clr, e_rd, e_acc, e_ov, e_done;
      if (m_on) begin
         e_clr  = m_active && (m_cyc == 1);
         e_rd   = m_active && (m_cyc >= 2) && (m_reads < m_total) && (ofifo_valid === 1'b1);
         e_acc  = m_prev_rd;
         e_ov   = m_active && (m_reads == m_total) && (m_cyc >= m_last_read_cyc + 2) && (m_outs < m_n);
         e_done = m_active && (m_outs == m_n) && (m_cyc == m_fin_cyc + 1);

         chk("busy",      32'(busy),      32'(m_active));
         chk("sfu_clr",   32'(sfu_clr),   32'(e_clr));
         chk("ofifo_rd",  32'(ofifo_rd),  32'(e_rd));
         chk("sfu_acc",   32'(sfu_acc),   32'(e_acc));
         chk("out_valid", 32'(out_valid), 32'(e_ov));
         chk("sfu_relu",  32'(sfu_relu),  32'(e_ov));
         chk("done",      32'(done),      32'(e_done));
         if (e_acc) chk("acc_sel", 32'(sfu_sel), 32'((m_reads - 1) % m_n));
         else if (e_ov) chk("out_sel", 32'(sfu_sel), 32'(m_outs));

         if (ofifo_rd === 1'b1) mon_reads++;
         if (out_valid === 1'b1 && out_ready === 1'b1) mon_outs++;
         if (done === 1'b1) mon_done++;
         if (out_valid === 1'b1 && sfu_sel == 4'd5) mon_sel5++;

         if (reset === 1'b1) begin
            m_active  = 1'b0;
            m_prev_rd = 1'b0;
         end else if (!m_active) begin
            m_prev_rd = 1'b0;
            if (start === 1'b1) begin
               m_active        = 1'b1;
               m_cyc           = 1;
               m_n             = int'(cfg_last_row) + 1;
               m_total         = m_n * (int'(cfg_last_pass) + 1);
               m_reads         = 0;
               m_outs          = 0;
               m_last_read_cyc = 0;
               m_fin_cyc       = 0;
            end
         end else begin
            m_prev_rd = e_rd;
            if (e_rd) begin
               m_reads++;
               if (m_reads == m_total) m_last_read_cyc = m_cyc;
            end
            if (e_ov && out_ready === 1'b1) begin
               m_outs++;
               if (m_outs == m_n) m_fin_cyc = m_cyc;
            end
            if (e_done) m_active = 1'b0;
            m_cyc++;
         end
      end
   end

   task automatic run_job(input int lr, input int lp, input int vm, input int rm,
                          input bit inject, output int lat);
      vmode     = vm;
      rmode     = rm;
      bp_cnt    = 0;
      mon_reads = 0;
      mon_outs  = 0;
      mon_sel5  = 0;
      @(posedge clk); #1;
      cfg_last_row  = 4'(lr);
      cfg_last_pass = 4'(lp);
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (inject) begin
         cfg_last_row  = 4'(~lr);
         cfg_last_pass = 4'(lp + 5);
      end
      lat = 0;
      while (lat < 3000) begin
         @(negedge clk); #1;
         lat++;
         if (inject && lat == 4) start = 1'b1;
         if (inject && lat == 5) start = 1'b0;
         if (done === 1'b1) break;
      end
      if (done !== 1'b1) chk("job_timeout", 32'(done), 32'd1);
      if (inject) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=hang required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, d0, lr, lp;
      reset         = 1'b1;
      start         = 1'b0;
      cfg_last_row  = '0;
      cfg_last_pass = '0;
      ofifo_valid   = 1'b0;
      out_ready     = 1'b1;
      @(posedge clk); #1;
      m_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_sel",     32'(sfu_sel), 32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_ofifo_rd",32'(ofifo_rd),32'd0);

      // Basic job: 8 reads, 4 outputs, done 15 cycles after the start edge.
      run_job(3, 1, 0, 0, 1'b0, lat);
      chk("basic_lat",   32'(lat),       32'd15);
      chk("basic_reads", 32'(mon_reads), 32'd8);
      chk("basic_outs",  32'(mon_outs),  32'd4);

      run_job(3, 1, 1, 0, 1'b0, lat);
      chk("stall_reads", 32'(mon_reads), 32'd8);
      chk("stall_outs",  32'(mon_outs),  32'd4);

      run_job(15, 0, 0, 2, 1'b0, lat);
      chk("bp_reads", 32'(mon_reads), 32'd16);
      chk("bp_outs",  32'(mon_outs),  32'd16);
      chk("bp_sel5",  32'(mon_sel5),  32'd4);

      run_job(0, 0, 0, 0, 1'b0, lat);
      chk("degen_lat",   32'(lat),       32'd5);
      chk("degen_reads", 32'(mon_reads), 32'd1);
      chk("degen_outs",  32'(mon_outs),  32'd1);

      run_job(3, 1, 0, 0, 1'b1, lat);
      chk("inject_reads", 32'(mon_reads), 32'd8);
      chk("inject_outs",  32'(mon_outs),  32'd4);
      repeat (3) @(negedge clk);
      #1 chk("inject_idle", 32'(busy), 32'd0);

      // Reset in the middle of ACCUM aborts without a done pulse.
      vmode = 0;
      rmode = 0;
      @(posedge clk); #1;
      cfg_last_row  = 4'd3;
      cfg_last_pass = 4'd1;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      chk("abort_busy",      32'(busy),      32'd0);
      chk("abort_acc",       32'(sfu_acc),   32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_ofifo_rd",  32'(ofifo_rd),  32'd0);
      d0 = mon_done;
      repeat (30) @(negedge clk);
      chk("abort_no_done", 32'(mon_done), 32'(d0));

      run_job(3, 1, 0, 0, 1'b0, lat);
      chk("post_rst_lat",   32'(lat),       32'd15);
      chk("post_rst_reads", 32'(mon_reads), 32'd8);

      for (int j = 0; j < 6; j++) begin
         lr = int'($urandom % 16);
         lp = int'($urandom % 4);
         run_job(lr, lp, 2, 1, 1'b0, lat);
         chk("rand_reads", 32'(mon_reads), 32'((lr + 1) * (lp + 1)));
         chk("rand_outs",  32'(mon_outs),  32'(lr + 1));
      end

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
